move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000, meaning the number of stable cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 20, meaning the frame_tick count from the held-press edge to the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 8, meaning the frame_tick count between subsequent auto-repeats.
REQ-004 SHALL have port clk_25MHz  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports btn_left, btn_right, btn_drop  in  1 each  raw asynchronous button levels (1 = pressed).
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse marking the start of vertical blanking.
REQ-008 SHALL have port game_over  in  1  level; high while the game core reports a winner or a full board.
REQ-009 SHALL have ports move_left, move_right, drop_piece  out  1 each  registered one-cycle command pulses to the game core.
REQ-010 SHALL have port new_game  out  1  registered one-cycle pulse requesting a board clear.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer.
REQ-013 SHALL, per button, update the debounced level only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; the counter clears on any cycle where the two levels match.
REQ-014 SHALL generate a press event on a 0->1 transition of a debounced level.
REQ-015 SHALL, while debounced left or right stays high, generate repeat events after REPEAT_DELAY frame_ticks and then every REPEAT_RATE frame_ticks; drop never repeats; release clears the repeat counter.
REQ-016 SHALL resolve same-cycle events by priority DROP > LEFT > RIGHT, except that LEFT and RIGHT together without DROP are both discarded.
REQ-017 SHALL encode commands as NONE, LEFT, RIGHT, DROP, NEW in a 3-bit pending register.
REQ-018 SHALL implement FSM states IDLE, PENDING, ISSUE, HOLDOFF.
REQ-019 IDLE: a resolved event latches into pending -> PENDING; a frame_tick in the same cycle is not consumed.
REQ-020 PENDING: frame_tick -> ISSUE; all events arriving in PENDING, ISSUE or HOLDOFF are discarded (no overwrite, no queue).
REQ-021 ISSUE: for exactly one cycle, assert the output matching pending, gated by game_over sampled that cycle; then clear pending -> HOLDOFF.
REQ-022 SHALL, at ISSUE, convert DROP to a new_game pulse when game_over=1, and suppress LEFT/RIGHT when game_over=1.
REQ-023 HOLDOFF: next frame_tick -> IDLE, guaranteeing at most one command per frame.
REQ-024 Latency: the command pulse SHALL appear on the cycle after the first frame_tick following the event latch.
REQ-025 All command outputs SHALL be mutually exclusive in every cycle.

Reset
REQ-026 rst SHALL force FSM=IDLE, pending=NONE, all outputs 0, synchronizers, debounced levels, debounce and repeat counters to 0, in the cycle after assertion.
REQ-027 rst asserted mid-ISSUE SHALL cancel the pulse if sampled in the same edge; no command survives reset.

Structure
REQ-028 Command encoding, FSM state encoding and default DB_CYCLES/REPEAT values SHALL reside in shared package connect_four_pkg.
REQ-029 Synchronizer, debounce counter and edge detect SHALL form sub-module button_debounce, instantiated three times.

Verification (DB_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2 on bench)
REQ-030 btn_left high 10 cycles, frame_tick every 50 cycles -> exactly one move_left pulse, one cycle after the next frame_tick.
REQ-031 btn_drop glitch high 3 cycles -> no event, busy stays 0.
REQ-032 btn_left and btn_right pressed same cycle -> no command; with btn_drop also pressed -> one drop_piece only.
REQ-033 btn_right held across 10 frame_ticks -> move_right at ticks 1, 4, 6, 8, 10 after the latch, never two in one frame.
REQ-034 btn_drop pressed with game_over=1 -> one new_game pulse, drop_piece stays 0; move_left pressed with game_over=1 -> no output.
REQ-035 rst asserted while PENDING -> busy=0 next cycle, no pulse on following frame_tick.

Source files
------------

// File: rtl/connect_four_pkg.sv
// Shared types and defaults for the Connect Four input/command path.
package connect_four_pkg;

  // Commands held in the scheduler's pending register.
  typedef enum logic [2:0] {
    CmdNone  = 3'd0,
    CmdLeft  = 3'd1,
    CmdRight = 3'd2,
    CmdDrop  = 3'd3,
    CmdNew   = 3'd4
  } cmd_e;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StIssue   = 2'd2,
    StHoldoff = 2'd3
  } sched_state_e;

  // 10 ms of stable level at 25 MHz.
  localparam int unsigned DefaultDbCycles    = 250000;
  localparam int unsigned DefaultRepeatDelay = 20;
  localparam int unsigned DefaultRepeatRate  = 8;

  // Same-cycle arbitration: drop wins; left+right together cancel each other.
  function automatic cmd_e resolve_cmd(input logic left, input logic right, input logic drop);
    if (drop) return CmdDrop;
    if (left && !right) return CmdLeft;
    if (right && !left) return CmdRight;
    return CmdNone;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Button, frame and command signals between the board inputs, the scheduler and the game core.
interface move_scheduler_if;
  logic btn_left;
  logic btn_right;
  logic btn_drop;
  logic frame_tick;
  logic game_over;
  logic move_left;
  logic move_right;
  logic drop_piece;
  logic new_game;
  logic busy;

  // Stimulus / game-core side.
  modport master (
    output btn_left, btn_right, btn_drop, frame_tick, game_over,
    input  move_left, move_right, drop_piece, new_game, busy
  );

  // Scheduler side.
  modport slave (
    input  btn_left, btn_right, btn_drop, frame_tick, game_over,
    output move_left, move_right, drop_piece, new_game, busy
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stable-level debounce counter and rising-edge press detect.
module button_debounce
  import connect_four_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DefaultDbCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic [1:0]      sync_d, sync_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            level_d, level_q;
  logic            press_d, press_q;

  // Count consecutive disagreeing cycles; flip the level on the DB_CYCLES-th one.
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/move_scheduler.sv
// Turns debounced button presses and auto-repeats into at most one game command per frame.
module move_scheduler
  import connect_four_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = DefaultDbCycles,
  parameter int unsigned REPEAT_DELAY = DefaultRepeatDelay,
  parameter int unsigned REPEAT_RATE  = DefaultRepeatRate
) (
  input logic             clk_25MHz,
  input logic             rst,
  move_scheduler_if.slave bus
);

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);
  // Only left and right auto-repeat; index order is {drop, right, left}.
  localparam logic [2:0] RptEnable = 3'b011;

  logic [2:0] level, press, ev;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk_i   (clk_25MHz),
    .rst_i   (rst),
    .btn_i   (bus.btn_left),
    .level_o (level[0]),
    .press_o (press[0])
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk_i   (clk_25MHz),
    .rst_i   (rst),
    .btn_i   (bus.btn_right),
    .level_o (level[1]),
    .press_o (press[1])
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_drop (
    .clk_i   (clk_25MHz),
    .rst_i   (rst),
    .btn_i   (bus.btn_drop),
    .level_o (level[2]),
    .press_o (press[2])
  );

  logic [RptW-1:0] rpt_cnt_d [3];
  logic [RptW-1:0] rpt_cnt_q [3];
  logic [2:0]      rpt_arm_d, rpt_arm_q;
  logic [2:0]      rpt_evt_d, rpt_evt_q;

  // Frame-tick counter per held button; first target is the delay, then the rate.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      rpt_arm_d[i] = rpt_arm_q[i];
      rpt_evt_d[i] = 1'b0;
      if (!level[i] || !RptEnable[i]) begin
        rpt_cnt_d[i] = '0;
        rpt_arm_d[i] = 1'b0;
      end else if (bus.frame_tick) begin
        if (rpt_cnt_q[i] == (rpt_arm_q[i] ? RateLast : DelayLast)) begin
          rpt_evt_d[i] = 1'b1;
          rpt_cnt_d[i] = '0;
          rpt_arm_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RptW'(1);
        end
      end
    end
  end

  // Auto-repeat registers.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) rpt_cnt_q[i] <= '0;
      rpt_arm_q <= '0;
      rpt_evt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      rpt_arm_q <= rpt_arm_d;
      rpt_evt_q <= rpt_evt_d;
    end
  end

  assign ev = press | rpt_evt_q;

  cmd_e         ev_cmd;
  cmd_e         pending_d, pending_q;
  sched_state_e state_d, state_q;
  logic         move_left_d, move_left_q;
  logic         move_right_d, move_right_q;
  logic         drop_piece_d, drop_piece_q;
  logic         new_game_d, new_game_q;
  logic         busy_d, busy_q;

  assign ev_cmd = resolve_cmd(ev[0], ev[1], ev[2]);

  // Scheduler next state. The command pulse is launched on the PENDING->ISSUE edge so it is
  // visible during the ISSUE cycle, i.e. the cycle right after the frame tick.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    drop_piece_d = 1'b0;
    new_game_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A tick coinciding with the latch is deliberately not consumed.
        if (ev_cmd != CmdNone) begin
          pending_d = ev_cmd;
          state_d   = StPending;
        end
      end
      StPending: begin
        if (bus.frame_tick) begin
          state_d = StIssue;
          case (pending_q)
            CmdDrop: begin
              new_game_d   = bus.game_over;
              drop_piece_d = ~bus.game_over;
            end
            CmdLeft:  move_left_d  = ~bus.game_over;
            CmdRight: move_right_d = ~bus.game_over;
            default:  ;
          endcase
        end
      end
      StIssue: begin
        pending_d = CmdNone;
        state_d   = StHoldoff;
      end
      StHoldoff: begin
        if (bus.frame_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q      <= StIdle;
      pending_q    <= CmdNone;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      drop_piece_q <= 1'b0;
      new_game_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      drop_piece_q <= drop_piece_d;
      new_game_q   <= new_game_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.drop_piece = drop_piece_q;
  assign bus.new_game   = new_game_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomized and directed bench for move_scheduler against a frame-slot reference model.
module tb_move_scheduler;

  localparam int Db   = 4;
  localparam int Dly  = 3;
  localparam int Rate = 2;

  localparam int MNone  = 0;
  localparam int MLeft  = 1;
  localparam int MRight = 2;
  localparam int MDrop  = 3;

  logic clk = 1'b0;
  logic rst;

  move_scheduler_if bus ();

  move_scheduler #(
    .DB_CYCLES    (Db),
    .REPEAT_DELAY (Dly),
    .REPEAT_RATE  (Rate)
  ) dut (
    .clk_25MHz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #20 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button index 0=left 1=right 2=drop.
  bit hist [3][Db+2];  // hist[b][k] = raw level sampled k edges ago
  bit lvl  [3];
  int held [3];        // frame ticks seen while debounced level high
  bit ev   [3];        // events produced at the previous edge
  int waiting;         // command waiting for its frame slot
  bit fire_now;        // a command pulse is on the outputs this cycle
  bit hold;            // slot used, waiting for the next frame tick
  bit e_left, e_right, e_drop, e_new;

  int n_left, n_right, n_drop, n_new, n_busy;
  int tcnt;
  int tick_period;     // >0 periodic, 0 random, <0 never

  task automatic model_edge();
    bit [2:0] raw;
    bit       tk, go, diff_all, lvl_new;
    bit       nev [3];
    raw = {bus.btn_drop, bus.btn_right, bus.btn_left};
    tk  = bus.frame_tick;
    go  = bus.game_over;
    e_left = 0; e_right = 0; e_drop = 0; e_new = 0;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < Db + 2; k++) hist[b][k] = 0;
        lvl[b] = 0; held[b] = 0; ev[b] = 0;
      end
      waiting = MNone; fire_now = 0; hold = 0;
      return;
    end
    // One command per frame slot.
    if (fire_now) begin
      fire_now = 0;
      hold     = 1;
    end else if (waiting != MNone) begin
      if (tk) begin
        case (waiting)
          MDrop:   if (go) e_new = 1; else e_drop = 1;
          MLeft:   e_left  = !go;
          MRight:  e_right = !go;
          default: ;
        endcase
        waiting  = MNone;
        fire_now = 1;
      end
    end else if (hold) begin
      if (tk) hold = 0;
    end else begin
      if (ev[2]) waiting = MDrop;
      else if (ev[0] && !ev[1]) waiting = MLeft;
      else if (ev[1] && !ev[0]) waiting = MRight;
    end
    // Button events: debounce window, press edge and repeat schedule.
    for (int b = 0; b < 3; b++) begin
      nev[b] = 0;
      if (!lvl[b]) held[b] = 0;
      else if (tk && b < 2) begin
        held[b]++;
        if (held[b] == Dly || (held[b] > Dly && (held[b] - Dly) % Rate == 0)) nev[b] = 1;
      end
      diff_all = 1;
      for (int k = 2; k <= Db + 1; k++) if (hist[b][k] == lvl[b]) diff_all = 0;
      lvl_new = diff_all ? !lvl[b] : lvl[b];
      if (lvl_new && !lvl[b]) nev[b] = 1;
      lvl[b] = lvl_new;
      for (int k = Db + 1; k >= 2; k--) hist[b][k] = hist[b][k-1];
      hist[b][1] = raw[b];
      ev[b] = nev[b];
    end
  endtask

  task automatic compare_outputs();
    check_eq("move_left", int'(bus.move_left), int'(e_left));
    check_eq("move_right", int'(bus.move_right), int'(e_right));
    check_eq("drop_piece", int'(bus.drop_piece), int'(e_drop));
    check_eq("new_game", int'(bus.new_game), int'(e_new));
    check_eq("busy", int'(bus.busy), int'(waiting != MNone || fire_now || hold));
    check_eq("exclusive",
             int'($countones({bus.move_left, bus.move_right, bus.drop_piece, bus.new_game}) <= 1),
             1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
    n_left  += int'(bus.move_left);
    n_right += int'(bus.move_right);
    n_drop  += int'(bus.drop_piece);
    n_new   += int'(bus.new_game);
    n_busy  += int'(bus.busy);
    tcnt++;
    if (tick_period > 0) bus.frame_tick = (tcnt % tick_period == 0);
    else if (tick_period == 0) bus.frame_tick = ($urandom_range(0, 5) == 0);
    else bus.frame_tick = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
    bus.game_over = 0; bus.frame_tick = 0;
    tick_period = -1;
    step();
    step();
    rst = 1'b0;
    n_left = 0; n_right = 0; n_drop = 0; n_new = 0; n_busy = 0;
    tcnt = 0;
  endtask

  initial begin
    automatic int busy_seen = 0;
    rst = 1'b1;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
    bus.game_over = 0; bus.frame_tick = 0;

    // Reset state.
    reset_dut();
    check_eq("reset_busy", int'(bus.busy), 0);

    // Single left press: one pulse right after the next tick.
    reset_dut();
    tick_period = 50;
    bus.btn_left = 1;
    repeat (10) step();
    bus.btn_left = 0;
    repeat (60) step();
    check_eq("single_left_count", n_left, 1);
    check_eq("single_left_others", n_right + n_drop + n_new, 0);

    // Short glitch on drop is filtered.
    reset_dut();
    tick_period = 7;
    bus.btn_drop = 1;
    repeat (3) step();
    bus.btn_drop = 0;
    repeat (20) step();
    check_eq("glitch_busy_cycles", n_busy, 0);
    check_eq("glitch_cmds", n_drop + n_new, 0);

    // Left+right cancel; adding drop gives a single drop.
    reset_dut();
    tick_period = 15;
    bus.btn_left = 1; bus.btn_right = 1;
    repeat (8) step();
    bus.btn_left = 0; bus.btn_right = 0;
    repeat (40) step();
    check_eq("lr_cancel_cmds", n_left + n_right + n_drop, 0);
    bus.btn_left = 1; bus.btn_right = 1; bus.btn_drop = 1;
    repeat (8) step();
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
    repeat (40) step();
    check_eq("lrd_drop_count", n_drop, 1);
    check_eq("lrd_lr_count", n_left + n_right, 0);

    // Held right: initial move plus auto-repeats, one per frame at most.
    reset_dut();
    tick_period = 10;
    bus.btn_right = 1;
    repeat (100) step();
    bus.btn_right = 0;
    repeat (20) step();
    check_eq("repeat_right_count", n_right, 5);

    // Game over: drop becomes new_game, moves are suppressed.
    reset_dut();
    tick_period = 15;
    bus.game_over = 1;
    bus.btn_drop = 1;
    repeat (8) step();
    bus.btn_drop = 0;
    repeat (40) step();
    check_eq("gameover_new_count", n_new, 1);
    check_eq("gameover_drop_count", n_drop, 0);
    bus.btn_left = 1;
    repeat (8) step();
    bus.btn_left = 0;
    repeat (40) step();
    check_eq("gameover_left_count", n_left, 0);
    check_eq("gameover_new_after_left", n_new, 1);
    bus.game_over = 0;

    // Reset while a command is pending cancels it.
    reset_dut();
    tick_period = -1;
    bus.btn_left = 1;
    for (int i = 0; i < 30 && busy_seen == 0; i++) begin
      step();
      if (bus.busy) busy_seen = 1;
    end
    check_eq("pending_reached", busy_seen, 1);
    bus.btn_left = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("pending_rst_busy", int'(bus.busy), 0);
    tick_period = 10;
    repeat (30) step();
    check_eq("pending_rst_cmds", n_left + n_right + n_drop + n_new, 0);

    // Randomized traffic against the model.
    reset_dut();
    tick_period = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.btn_left  = ~bus.btn_left;
      if ($urandom_range(0, 9) == 0) bus.btn_right = ~bus.btn_right;
      if ($urandom_range(0, 9) == 0) bus.btn_drop  = ~bus.btn_drop;
      if ($urandom_range(0, 59) == 0) bus.game_over = ~bus.game_over;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
